// File: rtl/clock_pkg.sv
// Shared definitions for the clock set controller: mode encoding, default
// debounce/repeat lengths and the mode-button sequencing rule.
package clock_pkg;

    localparam logic [1:0] MODE_RUN     = 2'd0;
    localparam logic [1:0] MODE_SET_MIN = 2'd1;
    localparam logic [1:0] MODE_SET_HR  = 2'd2;

    localparam int DEBOUNCE_LEN_DEFAULT = 3;
    localparam int REPEAT_DELAY_DEFAULT = 4;

    // Encoding 3 is unreachable but still falls back to RUN.
    function automatic logic [1:0] next_mode(input logic [1:0] mode);
        case (mode)
            MODE_RUN:     next_mode = MODE_SET_MIN;
            MODE_SET_MIN: next_mode = MODE_SET_HR;
            default:      next_mode = MODE_RUN;
        endcase
    endfunction

endpackage

// File: rtl/button_debounce.sv
// Raw button -> 2-flop synchronizer -> strobe-sampled debouncer -> press pulse.
// After reset the button must be seen released before any press is accepted.
module button_debounce
    import clock_pkg::*;
#(
    parameter int DEBOUNCE_LEN = DEBOUNCE_LEN_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic i_stb,
    input  logic i_btn,
    output logic o_level,
    output logic o_press
);
    localparam int CW = $clog2(DEBOUNCE_LEN + 1);

    logic          sync1_reg, sync2_reg;
    logic          level_reg, level_next;
    logic          press_reg, press_next;
    logic          blocked_reg, blocked_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic          target;

    always_comb begin
        level_next   = level_reg;
        press_next   = 1'b0;
        blocked_next = blocked_reg;
        cnt_next     = cnt_reg;
        // While locked out, count released samples instead of level changes.
        target       = blocked_reg ? 1'b0 : ~level_reg;
        if (i_stb) begin
            if (sync2_reg != target) begin
                cnt_next = '0;
            end else if (cnt_reg == CW'(DEBOUNCE_LEN - 1)) begin
                cnt_next = '0;
                if (blocked_reg) begin
                    blocked_next = 1'b0;
                end else begin
                    level_next = target;
                    press_next = target;
                end
            end else begin
                cnt_next = cnt_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_reg   <= 1'b0;
            sync2_reg   <= 1'b0;
            level_reg   <= 1'b0;
            press_reg   <= 1'b0;
            blocked_reg <= 1'b1;
            cnt_reg     <= '0;
        end else begin
            sync1_reg   <= i_btn;
            sync2_reg   <= sync1_reg;
            level_reg   <= level_next;
            press_reg   <= press_next;
            blocked_reg <= blocked_next;
            cnt_reg     <= cnt_next;
        end
    end

    assign o_level = level_reg;
    assign o_press = press_reg;

endmodule

// File: rtl/clock_set_controller.sv
// Generates registered count/clear enables for the seconds/minutes/hours chain
// from the 1 Hz tick in RUN, or from the debounced inc button in the set modes.
module clock_set_controller
    import clock_pkg::*;
#(
    parameter int DEBOUNCE_LEN = DEBOUNCE_LEN_DEFAULT,
    parameter int REPEAT_DELAY = REPEAT_DELAY_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_tick_1hz,
    input  logic       i_fast_stb,
    input  logic       i_mode_btn,
    input  logic       i_inc_btn,
    input  logic       i_sec_ovf,
    input  logic       i_min_ovf,
    output logic       o_sec_en,
    output logic       o_min_en,
    output logic       o_hr_en,
    output logic       o_sec_clear,
    output logic [1:0] o_mode
);
    localparam int              RW      = $clog2(REPEAT_DELAY + 1);
    localparam logic [RW-1:0]   RPT_SAT = RW'(REPEAT_DELAY);

    logic [1:0] btn_raw, btn_level, btn_press;
    logic       mode_press, inc_press, inc_level, inc_fire;
    logic       unused_mode_level;

    logic [1:0]    mode_reg, mode_next;
    logic          sec_en_reg, sec_en_next;
    logic          min_en_reg, min_en_next;
    logic          hr_en_reg, hr_en_next;
    logic          sec_clear_reg, sec_clear_next;
    logic          armed_reg, armed_next;
    logic [RW-1:0] rpt_reg, rpt_next;

    assign btn_raw = {i_inc_btn, i_mode_btn};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_btn
            button_debounce #(.DEBOUNCE_LEN(DEBOUNCE_LEN)) u_debounce (
                .clk    (clk),
                .reset  (reset),
                .i_stb  (i_fast_stb),
                .i_btn  (btn_raw[gi]),
                .o_level(btn_level[gi]),
                .o_press(btn_press[gi])
            );
        end
    endgenerate

    assign mode_press = btn_press[0];
    assign inc_press  = btn_press[1];
    assign inc_level  = btn_level[1];
    // The mode button acts only on its press edge.
    assign unused_mode_level = btn_level[0];

    // An inc held across a mode change stays disarmed until it is released.
    assign inc_fire = armed_reg &
                      (inc_press | (i_fast_stb & inc_level & (rpt_reg == RPT_SAT)));

    always_comb begin
        mode_next  = mode_reg;
        armed_next = armed_reg | ~inc_level;
        rpt_next   = rpt_reg;
        if (~inc_level | ~armed_reg)
            rpt_next = '0;
        else if (i_fast_stb && rpt_reg != RPT_SAT)
            rpt_next = rpt_reg + 1'b1;
        if (mode_press) begin
            mode_next  = next_mode(mode_reg);
            armed_next = ~inc_level;
            rpt_next   = '0;
        end
    end

    always_comb begin
        sec_en_next    = 1'b0;
        min_en_next    = 1'b0;
        hr_en_next     = 1'b0;
        sec_clear_next = mode_press & (mode_reg == MODE_RUN);
        case (mode_reg)
            MODE_RUN: begin
                sec_en_next = i_tick_1hz;
                min_en_next = i_tick_1hz & i_sec_ovf;
                hr_en_next  = i_tick_1hz & i_sec_ovf & i_min_ovf;
            end
            MODE_SET_MIN: min_en_next = inc_fire & ~mode_press;
            MODE_SET_HR:  hr_en_next  = inc_fire & ~mode_press;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mode_reg      <= MODE_RUN;
            sec_en_reg    <= 1'b0;
            min_en_reg    <= 1'b0;
            hr_en_reg     <= 1'b0;
            sec_clear_reg <= 1'b0;
            armed_reg     <= 1'b1;
            rpt_reg       <= '0;
        end else begin
            mode_reg      <= mode_next;
            sec_en_reg    <= sec_en_next;
            min_en_reg    <= min_en_next;
            hr_en_reg     <= hr_en_next;
            sec_clear_reg <= sec_clear_next;
            armed_reg     <= armed_next;
            rpt_reg       <= rpt_next;
        end
    end

    assign o_sec_en    = sec_en_reg;
    assign o_min_en    = min_en_reg;
    assign o_hr_en     = hr_en_reg;
    assign o_sec_clear = sec_clear_reg;
    assign o_mode      = mode_reg;

endmodule

// File: doc/clock_set_controller.md
Name: clock_set_controller

Overview:
- Sequences the time-keeping register chain (seconds, minutes, hours) of the digital clock.
- Outputs one-cycle count enables for each register.
- In RUN mode, enables are driven from the 1 Hz tick and the overflow flags fed back from the registers.
- Two user buttons select a time-set mode and increment the selected field, with auto-repeat while held.

Parameters:
- DEBOUNCE_LEN, 3, number of consecutive identical button samples (taken on i_fast_stb) required to accept a level change.
- REPEAT_DELAY, 4, number of i_fast_stb strobes the inc button must stay held before auto-repeat starts.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- i_tick_1hz  in  1  one-cycle strobe, once per second.
- i_fast_stb  in  1  one-cycle strobe at about 8 Hz; button sample and auto-repeat rate.
- i_mode_btn  in  1  raw asynchronous mode button, active-high.
- i_inc_btn  in  1  raw asynchronous increment button, active-high.
- i_sec_ovf  in  1  seconds register at 59 (combinational overflow flag from the register).
- i_min_ovf  in  1  minutes register at 59.
- o_sec_en  out  1  one-cycle count enable to the seconds register.
- o_min_en  out  1  one-cycle count enable to the minutes register.
- o_hr_en  out  1  one-cycle count enable to the hours register.
- o_sec_clear  out  1  one-cycle synchronous load-zero to the seconds register.
- o_mode  out  2  current mode: 0 RUN, 1 SET_MIN, 2 SET_HR (3 unused).

Behaviour:
- Reset:
  - o_sec_en, o_min_en, o_hr_en and o_sec_clear = 0; o_mode = RUN.
  - Debouncers are forced to the released state; repeat counter = 0; sync flops = 0.
  - Reset asserted mid-operation (e.g. inc held in SET_HR) returns to RUN on the next edge.
  - A button held across reset must be released and pressed again before it is acted on.
- Button path:
  - Each raw button passes a 2-flop synchronizer.
  - The synchronized level is sampled only on i_fast_stb cycles.
  - The debounced level changes after DEBOUNCE_LEN consecutive equal samples.
  - A press event is a one-cycle pulse on the debounced 0->1 transition.
- All outputs are registered: every enable pulse appears exactly 1 clk after its cause. Overflow inputs are sampled in the cause cycle.
- RUN:
  - On i_tick_1hz: o_sec_en = 1.
  - o_min_en = i_sec_ovf.
  - o_hr_en = i_sec_ovf & i_min_ovf.
  - No other enables are asserted.
- SET_MIN and SET_HR:
  - i_tick_1hz is ignored, so the clock is halted.
  - An inc press event gives one o_min_en (SET_MIN) or one o_hr_en (SET_HR) pulse.
  - The overflow inputs are ignored. A minutes wrap 59->00 in SET_MIN never pulses o_hr_en.
- Auto-repeat:
  - While inc stays debounced-high, the repeat counter increments on each i_fast_stb and saturates at REPEAT_DELAY.
  - Once saturated, each further i_fast_stb produces one enable pulse to the selected field.
  - The counter clears on release.
- Mode transitions, on a mode press event:
  - RUN -> SET_MIN, and o_sec_clear pulses once in the same cycle as the o_mode update.
  - SET_MIN -> SET_HR.
  - SET_HR -> RUN.
  - Encoding 3 (unreachable) -> RUN.
- Simultaneous events:
  - Mode press and inc press in the same cycle: the mode change wins and the inc event is discarded.
  - Inc held across a mode change: the repeat counter clears, and inc must be released before it takes effect in the new mode.
  - i_tick_1hz coinciding with the RUN->SET_MIN transition: the tick is still applied (o_sec_en pulses) because the state was RUN in that cycle. The clear is issued in the same cycle, and the register gives load priority, so seconds end at 00.
- At most one of o_sec_en / o_sec_clear is meaningful per cycle; the register is responsible for load-over-enable priority.

Decomposition:
- Shared package clock_pkg:
  - mode encoding constants MODE_RUN = 2'd0, MODE_SET_MIN = 2'd1, MODE_SET_HR = 2'd2.
  - default DEBOUNCE_LEN and REPEAT_DELAY constants.
- Sub-module button_debounce, instantiated twice.
  - Contains the synchronizer, the sample counter on i_fast_stb and the press-edge detector.
  - Ports: clk, reset, i_stb, i_btn, o_level, o_press.

Test Plan:
- RUN, i_sec_ovf=1, i_min_ovf=1, pulse i_tick_1hz -> next cycle o_sec_en=o_min_en=o_hr_en=1 for exactly 1 clk; with i_sec_ovf=0 only o_sec_en=1.
- Press mode clean for 3 fast strobes -> o_mode=1 and o_sec_clear=1 for one cycle; subsequent i_tick_1hz gives no enables.
- SET_MIN, i_min_ovf=1, single inc press -> exactly one o_min_en, o_hr_en stays 0; bouncy inc (toggling each sample) gives no pulse.
- SET_HR, hold inc for 10 fast strobes -> 1 pulse at debounce, then 1 o_hr_en per strobe after the 4-strobe delay; release stops pulses.
- Mode and inc press in same cycle in SET_MIN -> o_mode=2, no o_min_en/o_hr_en; third mode press returns o_mode=0.
- Reset asserted while inc held in SET_HR -> next cycle o_mode=0, all outputs 0; no pulses until inc released and re-pressed.
